// File: rtl/rob_retire_unit.sv
// rob_retire_unit: in-order reorder buffer and retire stage.
// Dispatch allocates entries in program order at the tail. Functional units
// complete entries out of order. Up to RET_W finished entries leave from the
// head each cycle as register-file writes or memory stores.
// Optional feature: define ROB_FLUSH_EN to add i_flush, which discards every
// pending entry at a clock edge.
module rob_retire_unit #(
  parameter int DEPTH  = 16,
  parameter int DISP_W = 2,
  parameter int CMPL_W = 3,
  parameter int RET_W  = 2,
  parameter int PREG_W = 6,
  parameter int XLEN   = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
`ifdef ROB_FLUSH_EN
  input  logic                     i_flush,
`endif
  input  logic [DISP_W-1:0]        i_alloc_valid,
  input  logic [DISP_W-1:0]        i_alloc_regwrite,
  input  logic [DISP_W-1:0]        i_alloc_memwrite,
  input  logic [DISP_W*PREG_W-1:0] i_alloc_pdst,
  output logic                     o_alloc_ready,
  output logic [DISP_W*IDX_W-1:0]  o_alloc_idx,
  input  logic [CMPL_W-1:0]        i_cmpl_valid,
  input  logic [CMPL_W*IDX_W-1:0]  i_cmpl_idx,
  input  logic [CMPL_W*XLEN-1:0]   i_cmpl_data,
  output logic [RET_W-1:0]         o_reg_w_en,
  output logic [RET_W*PREG_W-1:0]  o_reg_w_addr,
  output logic [RET_W*XLEN-1:0]    o_reg_w_data,
  output logic [RET_W-1:0]         o_mem_w_en,
  output logic [RET_W*XLEN-1:0]    o_mem_w_addr,
  output logic [RET_W*PREG_W-1:0]  o_mem_src_preg,
  output logic [IDX_W:0]           o_count
);

  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  done;
  logic [DEPTH-1:0]  regw;
  logic [DEPTH-1:0]  memw;
  logic [PREG_W-1:0] pdst_q [DEPTH];
  logic [XLEN-1:0]   data_q [DEPTH];
  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              flush_now;
  logic              alloc_chain;
  logic [DISP_W-1:0] alloc_take;
  logic [IDX_W-1:0]  alloc_slot [DISP_W];
  logic [CNT_W-1:0]  n_alloc;
  logic              ret_chain;
  logic [RET_W-1:0]  ret_take;
  logic [IDX_W-1:0]  ret_slot [RET_W];
  logic [CNT_W-1:0]  n_ret;

`ifdef ROB_FLUSH_EN
  assign flush_now = i_flush;
`else
  assign flush_now = 1'b0;
`endif

  assign o_count       = count;
  assign o_alloc_ready = (DEPTH - int'(count)) >= DISP_W;

  // Allocation: tags come straight from tail; lanes are accepted only as a packed prefix
  always_comb begin
    alloc_chain = o_alloc_ready && !flush_now;
    alloc_take  = '0;
    n_alloc     = '0;
    o_alloc_idx = '0;
    for (int k = 0; k < DISP_W; k++) begin
      alloc_slot[k] = tail + IDX_W'(k);
      o_alloc_idx[k*IDX_W +: IDX_W] = alloc_slot[k];
      alloc_chain   = alloc_chain && i_alloc_valid[k];
      alloc_take[k] = alloc_chain;
      if (alloc_chain) begin
        n_alloc = n_alloc + CNT_W'(1);
      end
    end
  end

  // Retire selection: an unbroken run of busy and done entries starting at head
  always_comb begin
    ret_chain = !flush_now;
    ret_take  = '0;
    n_ret     = '0;
    for (int r = 0; r < RET_W; r++) begin
      ret_slot[r] = head + IDX_W'(r);
      ret_chain   = ret_chain && busy[ret_slot[r]] && done[ret_slot[r]];
      ret_take[r] = ret_chain;
      if (ret_chain) begin
        n_ret = n_ret + CNT_W'(1);
      end
    end
  end

  // Control state: entry flags, pointers and occupancy; flush overrides everything
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy  <= '0;
      done  <= '0;
      regw  <= '0;
      memw  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_now) begin
      busy  <= '0;
      done  <= '0;
      tail  <= head;
      count <= '0;
    end else begin
      for (int c = 0; c < CMPL_W; c++) begin
        if (i_cmpl_valid[c] && busy[i_cmpl_idx[c*IDX_W +: IDX_W]]) begin
          done[i_cmpl_idx[c*IDX_W +: IDX_W]] <= 1'b1;
        end
      end
      for (int r = 0; r < RET_W; r++) begin
        if (ret_take[r]) begin
          busy[ret_slot[r]] <= 1'b0;
        end
      end
      for (int k = 0; k < DISP_W; k++) begin
        if (alloc_take[k]) begin
          busy[alloc_slot[k]] <= 1'b1;
          done[alloc_slot[k]] <= 1'b0;
          regw[alloc_slot[k]] <= i_alloc_regwrite[k];
          memw[alloc_slot[k]] <= i_alloc_memwrite[k];
        end
      end
      head  <= head + IDX_W'(n_ret);
      tail  <= tail + IDX_W'(n_alloc);
      count <= count + n_alloc - n_ret;
    end
  end

  // Entry payload needs no reset: it is only read once its entry is busy and done
  always_ff @(posedge i_clk) begin
    if (!flush_now) begin
      for (int c = 0; c < CMPL_W; c++) begin
        if (i_cmpl_valid[c] && busy[i_cmpl_idx[c*IDX_W +: IDX_W]]) begin
          data_q[i_cmpl_idx[c*IDX_W +: IDX_W]] <= i_cmpl_data[c*XLEN +: XLEN];
        end
      end
      for (int k = 0; k < DISP_W; k++) begin
        if (alloc_take[k]) begin
          pdst_q[alloc_slot[k]] <= i_alloc_pdst[k*PREG_W +: PREG_W];
        end
      end
    end
  end

  // Retire outputs: one-cycle pulses per retiring lane, stores take precedence over reg writes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_reg_w_en     <= '0;
      o_reg_w_addr   <= '0;
      o_reg_w_data   <= '0;
      o_mem_w_en     <= '0;
      o_mem_w_addr   <= '0;
      o_mem_src_preg <= '0;
    end else begin
      o_reg_w_en     <= '0;
      o_reg_w_addr   <= '0;
      o_reg_w_data   <= '0;
      o_mem_w_en     <= '0;
      o_mem_w_addr   <= '0;
      o_mem_src_preg <= '0;
      for (int r = 0; r < RET_W; r++) begin
        if (ret_take[r]) begin
          if (memw[ret_slot[r]]) begin
            o_mem_w_en[r]                       <= 1'b1;
            o_mem_w_addr[r*XLEN +: XLEN]        <= data_q[ret_slot[r]];
            o_mem_src_preg[r*PREG_W +: PREG_W]  <= pdst_q[ret_slot[r]];
          end else if (regw[ret_slot[r]]) begin
            o_reg_w_en[r]                       <= 1'b1;
            o_reg_w_addr[r*PREG_W +: PREG_W]    <= pdst_q[ret_slot[r]];
            o_reg_w_data[r*XLEN +: XLEN]        <= data_q[ret_slot[r]];
          end
        end
      end
    end
  end

endmodule
